// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned ADJ_THRESH  = 5;
    localparam int unsigned ADJ_ADD     = 3;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Input and result handshake bundle for bin2bcd_seq.
interface bin2bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
);

    logic                          in_valid;
    logic                          in_ready;
    logic [BIN_W-1:0]              bin_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
    logic                          overflow;

    // master: producer of values and consumer of results
    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, overflow
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, overflow
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more, 4-bit wrap.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(ADJ_THRESH)) begin
            dout = din + BCD_DIGIT_W'(ADJ_ADD);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIN_W-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W:0]   shifted;
    logic [BCD_W-1:0]       bcd_next;
    logic [BIN_W-1:0]       bin_next;
    logic                   carry_out;

    for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
        bcd_digit_adj u_adj (
            .din  (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // {bcd,bin} << 1 with the bit leaving the top digit kept as the overflow candidate
    assign shifted   = {bcd_adj, bin_q, 1'b0};
    assign carry_out = shifted[BCD_W+BIN_W];
    assign bcd_next  = shifted[BCD_W+BIN_W-1:BIN_W];
    assign bin_next  = shifted[BIN_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        bin_q      <= bus.bin_in;
                        bcd_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= CNT_LAST;
                        in_ready_q <= 1'b0;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    bin_q <= bin_next;
                    bcd_q <= bcd_next;
                    if (carry_out) begin
                        ovf_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.overflow  = ovf_q;

endmodule
